// File: rtl/reg_capture_ctrl_pkg.sv
// -----------------------------------------------------------------------------
// reg_capture_ctrl_pkg
// Shared definitions for the main capture-control register block: the block
// select code, register offsets, arm-FSM state encoding, error bit positions,
// the FIFO empty-marker fill bit and a bytes-per-width helper.
// -----------------------------------------------------------------------------
package reg_capture_ctrl_pkg;

    // reg_address[7:6] value that selects this register window.
    localparam logic [1:0] MAIN_REG_SELECT = 2'b00;

    // Register offsets within the window (reg_address[5:0]).
    localparam logic [5:0] REG_STATUS      = 6'd0;
    localparam logic [5:0] REG_ARM         = 6'd1;
    localparam logic [5:0] REG_CHAN_SEL    = 6'd2;
    localparam logic [5:0] REG_TRIG_ENABLE = 6'd3;
    localparam logic [5:0] REG_TRIG_DELAY  = 6'd4;
    localparam logic [5:0] REG_TRIG_WIDTH  = 6'd5;
    localparam logic [5:0] REG_CAPTURE_LEN = 6'd6;
    localparam logic [5:0] REG_PHASE_SHIFT = 6'd7;
    localparam logic [5:0] REG_FIFO_RD     = 6'd8;
    localparam logic [5:0] REG_ERROR       = 6'd9;

    typedef enum logic [1:0] {
        ST_IDLE      = 2'd0,
        ST_ARMED     = 2'd1,
        ST_CAPTURING = 2'd2,
        ST_DONE      = 2'd3
    } arm_state_e;

    // Sticky error bit positions in the ERROR register.
    localparam int ERR_FIFO_EMPTY = 0;
    localparam int ERR_PS_TIMEOUT = 1;
    localparam int ERR_PS_BUSY    = 2;
    localparam int ERR_CAPTURE    = 3;

    // A read of an empty FIFO latches a word filled with this bit.
    localparam logic FIFO_MARKER_BIT = 1'b1;

    function automatic int num_bytes(input int bits);
        return (bits + 7) / 8;
    endfunction

endpackage

// File: rtl/reg_capture_ctrl_ps_handshake.sv
// -----------------------------------------------------------------------------
// reg_capture_ctrl_ps_handshake
// Trigger-clock phase-shift handshake supervisor. A request while idle issues
// a one-cycle psen pulse with the latched direction and goes busy; busy ends
// on psdone or after pPS_TIMEOUT busy cycles (timeout error pulse). A request
// while busy is dropped and flagged.
// Ports:
//   clk, rst        clock, asynchronous active-high reset
//   req_i           phase-shift write strobe
//   incdec_i        requested direction
//   psdone_i        phase shift finished
//   psen_o          one-cycle phase-shift enable
//   psincdec_o      direction held for the request
//   busy_o          handshake in progress
//   timeout_err_o   pulse: psdone never arrived
//   busy_err_o      pulse: request arrived while busy
// -----------------------------------------------------------------------------
module reg_capture_ctrl_ps_handshake #(
    parameter int pPS_TIMEOUT = 255
) (
    input  logic clk,
    input  logic rst,
    input  logic req_i,
    input  logic incdec_i,
    input  logic psdone_i,
    output logic psen_o,
    output logic psincdec_o,
    output logic busy_o,
    output logic timeout_err_o,
    output logic busy_err_o
);

    localparam int CW = (pPS_TIMEOUT > 1) ? $clog2(pPS_TIMEOUT + 1) : 1;
    // Count runs 0 .. pPS_TIMEOUT-1 starting in the psen cycle.
    localparam logic [CW-1:0] LAST = CW'(pPS_TIMEOUT - 1);

    logic          psen_q, psen_d;
    logic          psincdec_q, psincdec_d;
    logic          busy_q, busy_d;
    logic [CW-1:0] count_q, count_d;

    always_comb begin
        psen_d        = 1'b0;
        psincdec_d    = psincdec_q;
        busy_d        = busy_q;
        count_d       = count_q;
        timeout_err_o = 1'b0;
        busy_err_o    = 1'b0;
        if (busy_q) begin
            busy_err_o = req_i;
            if (psdone_i) begin
                busy_d = 1'b0;
            end else if (count_q == LAST) begin
                busy_d        = 1'b0;
                timeout_err_o = 1'b1;
            end else begin
                count_d = count_q + 1'b1;
            end
        end else if (req_i) begin
            psen_d     = 1'b1;
            psincdec_d = incdec_i;
            busy_d     = 1'b1;
            count_d    = '0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            psen_q     <= 1'b0;
            psincdec_q <= 1'b0;
            busy_q     <= 1'b0;
            count_q    <= '0;
        end else begin
            psen_q     <= psen_d;
            psincdec_q <= psincdec_d;
            busy_q     <= busy_d;
            count_q    <= count_d;
        end
    end

    assign psen_o     = psen_q;
    assign psincdec_o = psincdec_q;
    assign busy_o     = busy_q;

endmodule

// File: rtl/reg_capture_ctrl.sv
// -----------------------------------------------------------------------------
// reg_capture_ctrl
// Main register window for multi-channel capture control: address decode,
// per-channel trigger delay/width, capture length, arm/capture FSM, byte-wise
// FIFO word reads with an empty marker, phase-shift handshake and sticky W1C
// error flags. All inputs are in the cwusb_clk domain.
// Ports:
//   cwusb_clk, reset_i                     clock, async active-high reset
//   reg_address/bytecnt/read/write/addrvalid, write_data   register bus in
//   read_data (registered), selected (combinational)       register bus out
//   I_fifo_data/I_fifo_empty, O_fifo_read  FWFT FIFO head and pop
//   I_capture_enable_pulse/I_capture_done, O_arm           capture sequencing
//   O_capture_len, O_trigger_enable/delay/width            capture settings
//   O_psen/O_psincdec, I_psdone            phase-shift handshake
// -----------------------------------------------------------------------------
module reg_capture_ctrl
    import reg_capture_ctrl_pkg::*;
#(
    parameter int pBYTECNT_SIZE      = 7,
    parameter int pNUM_CHANNELS      = 4,
    parameter int pDELAY_WIDTH       = 24,
    parameter int pCAPTURE_LEN_WIDTH = 24,
    parameter int pFIFO_WIDTH        = 18,
    parameter int pPS_TIMEOUT        = 255
) (
    input  logic                                  cwusb_clk,
    input  logic                                  reset_i,
    input  logic [7:0]                            reg_address,
    input  logic [pBYTECNT_SIZE-1:0]              reg_bytecnt,
    input  logic                                  reg_read,
    input  logic                                  reg_write,
    input  logic                                  reg_addrvalid,
    input  logic [7:0]                            write_data,
    output logic [7:0]                            read_data,
    output logic                                  selected,
    input  logic [pFIFO_WIDTH-1:0]                I_fifo_data,
    input  logic                                  I_fifo_empty,
    output logic                                  O_fifo_read,
    input  logic                                  I_capture_enable_pulse,
    input  logic                                  I_capture_done,
    output logic                                  O_arm,
    output logic [pCAPTURE_LEN_WIDTH-1:0]         O_capture_len,
    output logic [pNUM_CHANNELS-1:0]              O_trigger_enable,
    output logic [pNUM_CHANNELS*pDELAY_WIDTH-1:0] O_trigger_delay,
    output logic [pNUM_CHANNELS*pDELAY_WIDTH-1:0] O_trigger_width,
    output logic                                  O_psen,
    output logic                                  O_psincdec,
    input  logic                                  I_psdone
);

    localparam int NB  = num_bytes(pFIFO_WIDTH);
    localparam int DB  = num_bytes(pDELAY_WIDTH);
    localparam int CB  = num_bytes(pCAPTURE_LEN_WIDTH);
    localparam int BCW = pBYTECNT_SIZE;

    arm_state_e                   state_q, state_d;
    logic [7:0]                   chan_sel_q, chan_sel_d;
    logic [pNUM_CHANNELS-1:0]     trig_enable_q, trig_enable_d;
    logic [pDELAY_WIDTH-1:0]      delay_q [pNUM_CHANNELS], delay_d [pNUM_CHANNELS];
    logic [pDELAY_WIDTH-1:0]      width_q [pNUM_CHANNELS], width_d [pNUM_CHANNELS];
    logic [pCAPTURE_LEN_WIDTH-1:0] capture_len_q, capture_len_d;
    logic [3:0]                   err_q, err_d;
    logic [NB*8-1:0]              fifo_word_q, fifo_word_d;
    logic                         reg_read_q, reg_read_d;
    logic                         fifo_read_q, fifo_read_d;
    logic [7:0]                   read_data_q, read_data_d;

    logic [5:0]      offset;
    logic            wr_en, rd_en, bc_zero, arm_wr, ps_req;
    logic            ps_busy, ps_timeout_err, ps_busy_err;
    logic [BCW-1:0]  fifo_idx;
    logic            fifo_rise;
    logic [NB*8-1:0] fifo_src;
    logic            chan_valid;
    logic [DB*8-1:0] sel_delay_pad, sel_width_pad, new_delay_pad, new_width_pad;
    logic [CB*8-1:0] cap_pad, new_cap_pad;
    logic [7:0]      rd_byte;
    logic [3:0]      err_set, err_clr;

    assign selected = reg_addrvalid && (reg_address[7:6] == MAIN_REG_SELECT);
    assign offset   = reg_address[5:0];
    assign wr_en    = selected && reg_write;
    assign rd_en    = selected && reg_read;
    assign bc_zero  = (reg_bytecnt == '0);
    assign arm_wr   = wr_en && (offset == REG_ARM) && bc_zero;
    assign ps_req   = wr_en && (offset == REG_PHASE_SHIFT) && bc_zero;

    // ---------------- arm / capture FSM ----------------
    always_comb begin
        state_d = state_q;
        if (arm_wr && write_data[1]) begin
            state_d = ST_IDLE;  // abort overrides arm
        end else begin
            case (state_q)
                ST_IDLE, ST_DONE: if (arm_wr && write_data[0]) state_d = ST_ARMED;
                ST_ARMED:         if (I_capture_enable_pulse)  state_d = ST_CAPTURING;
                ST_CAPTURING:     if (I_capture_done)          state_d = ST_DONE;
                default:          state_d = ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge cwusb_clk or posedge reset_i) begin
        if (reset_i) state_q <= ST_IDLE;
        // NOTE: state elements use non-blocking assignment so every flop
        // samples pre-edge values regardless of statement order.
        else         state_q <= state_d;
    end

    assign O_arm = (state_q == ST_ARMED);

    // ---------------- phase-shift handshake ----------------
    reg_capture_ctrl_ps_handshake #(.pPS_TIMEOUT(pPS_TIMEOUT)) u_ps (
        .clk           (cwusb_clk),
        .rst           (reset_i),
        .req_i         (ps_req),
        .incdec_i      (write_data[0]),
        .psdone_i      (I_psdone),
        .psen_o        (O_psen),
        .psincdec_o    (O_psincdec),
        .busy_o        (ps_busy),
        .timeout_err_o (ps_timeout_err),
        .busy_err_o    (ps_busy_err)
    );

    // ---------------- register file, FIFO read path, read mux ----------------
    always_comb begin
        // NOTE: every combinational variable gets a default first so no path
        // leaves it unassigned, which would otherwise infer a latch.
        chan_sel_d    = chan_sel_q;
        trig_enable_d = trig_enable_q;
        delay_d       = delay_q;
        width_d       = width_q;
        capture_len_d = capture_len_q;
        fifo_word_d   = fifo_word_q;
        reg_read_d    = reg_read;
        chan_valid    = 1'b0;
        sel_delay_pad = '0;
        sel_width_pad = '0;
        cap_pad       = '0;
        rd_byte       = 8'h00;
        err_set       = '0;

        for (int c = 0; c < pNUM_CHANNELS; c++) begin
            if (chan_sel_q == 8'(c)) begin
                chan_valid                      = 1'b1;
                sel_delay_pad[pDELAY_WIDTH-1:0] = delay_q[c];
                sel_width_pad[pDELAY_WIDTH-1:0] = width_q[c];
            end
        end
        cap_pad[pCAPTURE_LEN_WIDTH-1:0] = capture_len_q;

        // Byte-merged versions; bytes past the register width leave it unchanged.
        new_delay_pad = sel_delay_pad;
        new_width_pad = sel_width_pad;
        new_cap_pad   = cap_pad;
        for (int b = 0; b < DB; b++) begin
            if (reg_bytecnt == BCW'(b)) begin
                new_delay_pad[b*8 +: 8] = write_data;
                new_width_pad[b*8 +: 8] = write_data;
            end
        end
        for (int b = 0; b < CB; b++) begin
            if (reg_bytecnt == BCW'(b)) new_cap_pad[b*8 +: 8] = write_data;
        end

        if (wr_en && bc_zero && offset == REG_CHAN_SEL)    chan_sel_d    = write_data;
        if (wr_en && bc_zero && offset == REG_TRIG_ENABLE) trig_enable_d = write_data[pNUM_CHANNELS-1:0];
        if (wr_en && offset == REG_CAPTURE_LEN) capture_len_d = new_cap_pad[pCAPTURE_LEN_WIDTH-1:0];
        for (int c = 0; c < pNUM_CHANNELS; c++) begin
            if (wr_en && chan_sel_q == 8'(c)) begin
                if (offset == REG_TRIG_DELAY) delay_d[c] = new_delay_pad[pDELAY_WIDTH-1:0];
                if (offset == REG_TRIG_WIDTH) width_d[c] = new_width_pad[pDELAY_WIDTH-1:0];
            end
        end

        // FIFO words stream as NB-byte groups; byte 0 of a group fetches a word.
        fifo_idx    = reg_bytecnt % BCW'(NB);
        fifo_rise   = rd_en && !reg_read_q && (offset == REG_FIFO_RD) && (fifo_idx == '0);
        fifo_read_d = fifo_rise && !I_fifo_empty;
        fifo_src    = '0;
        if (fifo_rise) begin
            if (I_fifo_empty) fifo_src[pFIFO_WIDTH-1:0] = {pFIFO_WIDTH{FIFO_MARKER_BIT}};
            else              fifo_src[pFIFO_WIDTH-1:0] = I_fifo_data;
            fifo_word_d = fifo_src;
        end else begin
            fifo_src = fifo_word_q;
        end

        case (offset)
            REG_STATUS:      if (bc_zero) rd_byte = {3'b000, |err_q, I_fifo_empty, ps_busy, state_q};
            REG_CHAN_SEL:    if (bc_zero) rd_byte = chan_sel_q;
            REG_TRIG_ENABLE: if (bc_zero) rd_byte[pNUM_CHANNELS-1:0] = trig_enable_q;
            REG_PHASE_SHIFT: if (bc_zero) rd_byte = {7'd0, O_psincdec};
            REG_ERROR:       if (bc_zero) rd_byte = {4'd0, err_q};
            REG_TRIG_DELAY, REG_TRIG_WIDTH: begin
                for (int b = 0; b < DB; b++) begin
                    if (chan_valid && reg_bytecnt == BCW'(b)) begin
                        rd_byte = (offset == REG_TRIG_DELAY) ? sel_delay_pad[b*8 +: 8]
                                                             : sel_width_pad[b*8 +: 8];
                    end
                end
            end
            REG_CAPTURE_LEN: begin
                for (int b = 0; b < CB; b++) begin
                    if (reg_bytecnt == BCW'(b)) rd_byte = cap_pad[b*8 +: 8];
                end
            end
            REG_FIFO_RD: begin
                for (int b = 0; b < NB; b++) begin
                    if (fifo_idx == BCW'(b)) rd_byte = fifo_src[b*8 +: 8];
                end
            end
            default: rd_byte = 8'h00;  // ARM is write-only; unused offsets read 0
        endcase
        read_data_d = rd_en ? rd_byte : 8'h00;

        // Sticky errors: write-1-to-clear, a same-cycle set takes priority.
        err_set[ERR_FIFO_EMPTY] = fifo_rise && I_fifo_empty;
        err_set[ERR_PS_TIMEOUT] = ps_timeout_err;
        err_set[ERR_PS_BUSY]    = ps_busy_err;
        err_set[ERR_CAPTURE]    = I_capture_enable_pulse && (state_q != ST_ARMED);
        err_clr = (wr_en && bc_zero && offset == REG_ERROR) ? write_data[3:0] : 4'd0;
        err_d   = (err_q & ~err_clr) | err_set;
    end

    always_ff @(posedge cwusb_clk or posedge reset_i) begin
        if (reset_i) begin
            chan_sel_q    <= '0;
            trig_enable_q <= '0;
            // NOTE: the channel arrays are plain flops driving outputs that must
            // be 0 out of reset, so they are reset like any other register.
            delay_q       <= '{default: '0};
            width_q       <= '{default: '0};
            capture_len_q <= '0;
            err_q         <= '0;
            fifo_word_q   <= '0;
            reg_read_q    <= 1'b0;
            fifo_read_q   <= 1'b0;
            read_data_q   <= '0;
        end else begin
            chan_sel_q    <= chan_sel_d;
            trig_enable_q <= trig_enable_d;
            delay_q       <= delay_d;
            width_q       <= width_d;
            capture_len_q <= capture_len_d;
            err_q         <= err_d;
            fifo_word_q   <= fifo_word_d;
            reg_read_q    <= reg_read_d;
            fifo_read_q   <= fifo_read_d;
            read_data_q   <= read_data_d;
        end
    end

    always_comb begin
        O_trigger_delay = '0;
        O_trigger_width = '0;
        for (int c = 0; c < pNUM_CHANNELS; c++) begin
            O_trigger_delay[c*pDELAY_WIDTH +: pDELAY_WIDTH] = delay_q[c];
            O_trigger_width[c*pDELAY_WIDTH +: pDELAY_WIDTH] = width_q[c];
        end
    end

    assign read_data        = read_data_q;
    assign O_fifo_read      = fifo_read_q;
    assign O_capture_len    = capture_len_q;
    assign O_trigger_enable = trig_enable_q;

endmodule

// File: tb/tb_reg_capture_ctrl.sv
module tb_reg_capture_ctrl;

    logic        cwusb_clk = 1'b0;
    logic        reset_i;
    logic [7:0]  reg_address;
    logic [6:0]  reg_bytecnt;
    logic        reg_read, reg_write, reg_addrvalid;
    logic [7:0]  write_data;
    logic [7:0]  read_data;
    logic        selected;
    logic [17:0] I_fifo_data;
    logic        I_fifo_empty;
    logic        O_fifo_read;
    logic        I_capture_enable_pulse, I_capture_done;
    logic        O_arm;
    logic [23:0] O_capture_len;
    logic [3:0]  O_trigger_enable;
    logic [95:0] O_trigger_delay, O_trigger_width;
    logic        O_psen, O_psincdec, I_psdone;

    int n_checks = 0;
    int n_errors = 0;
    int pop_count = 0;
    int psen_count = 0;

    // Behavioural model of the writable settings.
    int unsigned m_delay [4];
    int unsigned m_width [4];
    int unsigned m_cap;
    int unsigned m_chan;
    int unsigned m_en;

    reg_capture_ctrl dut (
        .cwusb_clk              (cwusb_clk),
        .reset_i                (reset_i),
        .reg_address            (reg_address),
        .reg_bytecnt            (reg_bytecnt),
        .reg_read               (reg_read),
        .reg_write              (reg_write),
        .reg_addrvalid          (reg_addrvalid),
        .write_data             (write_data),
        .read_data              (read_data),
        .selected               (selected),
        .I_fifo_data            (I_fifo_data),
        .I_fifo_empty           (I_fifo_empty),
        .O_fifo_read            (O_fifo_read),
        .I_capture_enable_pulse (I_capture_enable_pulse),
        .I_capture_done         (I_capture_done),
        .O_arm                  (O_arm),
        .O_capture_len          (O_capture_len),
        .O_trigger_enable       (O_trigger_enable),
        .O_trigger_delay        (O_trigger_delay),
        .O_trigger_width        (O_trigger_width),
        .O_psen                 (O_psen),
        .O_psincdec             (O_psincdec),
        .I_psdone               (I_psdone)
    );

    always #5 cwusb_clk = ~cwusb_clk;

    always @(posedge cwusb_clk) begin
        if (O_fifo_read) pop_count++;
        if (O_psen)      psen_count++;
    end

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // All bus tasks start and end on a falling edge and take one cycle.
    task automatic bus_write(input logic [7:0] addr, input int bc, input logic [7:0] d);
        reg_address = addr; reg_bytecnt = 7'(bc); write_data = d;
        reg_addrvalid = 1'b1; reg_write = 1'b1;
        @(negedge cwusb_clk);
        reg_write = 1'b0; reg_addrvalid = 1'b0;
    endtask

    task automatic bus_read(input logic [7:0] addr, input int bc, output logic [7:0] d);
        reg_address = addr; reg_bytecnt = 7'(bc);
        reg_addrvalid = 1'b1; reg_read = 1'b1;
        @(negedge cwusb_clk);
        d = read_data;
        reg_read = 1'b0; reg_addrvalid = 1'b0;
    endtask

    task automatic read_check(input string name, input logic [7:0] addr, input int bc,
                              input logic [7:0] exp);
        logic [7:0] v;
        bus_read(addr, bc, v);
        check(name, v, exp);
    endtask

    task automatic pulse(input int which);
        if (which == 0) I_capture_enable_pulse = 1'b1;
        if (which == 1) I_capture_done = 1'b1;
        if (which == 2) I_psdone = 1'b1;
        @(negedge cwusb_clk);
        I_capture_enable_pulse = 1'b0; I_capture_done = 1'b0; I_psdone = 1'b0;
    endtask

    task automatic do_reset();
        reset_i = 1'b1;
        repeat (2) @(negedge cwusb_clk);
        reset_i = 1'b0;
        @(negedge cwusb_clk);
    endtask

    function automatic logic [7:0] get_byte(input int unsigned v, input int bc, input int nbytes);
        int unsigned s;
        if (bc >= nbytes) return 8'h00;
        s = v >> (8 * bc);
        return s[7:0];
    endfunction

    function automatic int unsigned put_byte(input int unsigned v, input int bc, input int unsigned d);
        if (bc >= 3) return v;
        return ((v & ~(32'hFF << (8 * bc))) | (d << (8 * bc))) & 32'h00FF_FFFF;
    endfunction

    function automatic logic [7:0] model_read(input int off, input int bc);
        case (off)
            2: return (bc == 0) ? m_chan[7:0] : 8'h00;
            3: return (bc == 0) ? m_en[7:0] : 8'h00;
            4: return (m_chan < 4) ? get_byte(m_delay[m_chan], bc, 3) : 8'h00;
            5: return (m_chan < 4) ? get_byte(m_width[m_chan], bc, 3) : 8'h00;
            6: return get_byte(m_cap, bc, 3);
            default: return 8'h00;
        endcase
    endfunction

    task automatic model_write(input int off, input int bc, input int unsigned d);
        case (off)
            2: if (bc == 0) m_chan = d;
            3: if (bc == 0) m_en = d & 32'hF;
            4: if (m_chan < 4) m_delay[m_chan] = put_byte(m_delay[m_chan], bc, d);
            5: if (m_chan < 4) m_width[m_chan] = put_byte(m_width[m_chan], bc, d);
            6: m_cap = put_byte(m_cap, bc, d);
            default: ;
        endcase
    endtask

    typedef struct {
        bit         is_wr;
        logic [7:0] addr;
        int         bc;
        logic [7:0] data;
        logic [7:0] exp;
        string      name;
    } vec_t;

    initial begin
        vec_t       vecs[$];
        logic [7:0] rd;
        logic [95:0] exp_d, exp_w;
        int         pop_base;

        reset_i = 1'b1; reg_address = '0; reg_bytecnt = '0; reg_read = 0; reg_write = 0;
        reg_addrvalid = 0; write_data = '0; I_fifo_data = '0; I_fifo_empty = 1'b1;
        I_capture_enable_pulse = 0; I_capture_done = 0; I_psdone = 0;
        repeat (3) @(negedge cwusb_clk);
        reset_i = 1'b0;
        @(negedge cwusb_clk);

        // ---- reset state ----
        check("reset_outputs",
              {O_arm, O_capture_len, O_trigger_enable, O_trigger_delay, O_trigger_width,
               O_psen, O_psincdec, O_fifo_read, read_data}, '0);
        read_check("reset_status", 8'h00, 0, 8'h08);

        // ---- table-driven channel register vectors ----
        vecs.push_back('{1, 8'h02, 0, 8'h02, 8'h00, "w_chan2"});
        vecs.push_back('{1, 8'h04, 0, 8'h11, 8'h00, "w_dly0"});
        vecs.push_back('{1, 8'h04, 1, 8'h22, 8'h00, "w_dly1"});
        vecs.push_back('{1, 8'h04, 2, 8'h33, 8'h00, "w_dly2"});
        vecs.push_back('{1, 8'h04, 3, 8'h44, 8'h00, "w_dly3_ignored"});
        vecs.push_back('{0, 8'h04, 0, 8'h00, 8'h11, "r_dly0"});
        vecs.push_back('{0, 8'h04, 1, 8'h00, 8'h22, "r_dly1"});
        vecs.push_back('{0, 8'h04, 2, 8'h00, 8'h33, "r_dly2"});
        vecs.push_back('{0, 8'h04, 3, 8'h00, 8'h00, "r_dly3_past_width"});
        vecs.push_back('{1, 8'h42, 0, 8'h05, 8'h00, "w_unselected"});
        vecs.push_back('{0, 8'h02, 0, 8'h00, 8'h02, "r_chan_after_unselected"});
        vecs.push_back('{1, 8'h02, 0, 8'h07, 8'h00, "w_chan7"});
        vecs.push_back('{1, 8'h04, 0, 8'h55, 8'h00, "w_dly_bad_chan"});
        vecs.push_back('{0, 8'h04, 0, 8'h00, 8'h00, "r_dly_bad_chan"});
        vecs.push_back('{0, 8'h0C, 0, 8'h00, 8'h00, "r_unused_offset"});
        vecs.push_back('{1, 8'h02, 0, 8'h02, 8'h00, "w_chan2_again"});
        vecs.push_back('{0, 8'h04, 0, 8'h00, 8'h11, "r_dly0_kept"});
        foreach (vecs[i]) begin
            if (vecs[i].is_wr) bus_write(vecs[i].addr, vecs[i].bc, vecs[i].data);
            else               read_check(vecs[i].name, vecs[i].addr, vecs[i].bc, vecs[i].exp);
        end
        check("trigger_delay_vec", O_trigger_delay, 96'h000000_332211_000000_000000);
        reg_address = 8'h45; reg_addrvalid = 1'b1; #1;
        check("selected_other_window", selected, 1'b0);
        reg_address = 8'h05; #1;
        check("selected_main_window", selected, 1'b1);
        reg_addrvalid = 1'b0;
        @(negedge cwusb_clk);

        // ---- arm FSM ----
        bus_write(8'h01, 0, 8'h01);
        check("arm_out", O_arm, 1'b1);
        read_check("st_armed", 8'h00, 0, 8'h09);
        pulse(0);
        read_check("st_capturing", 8'h00, 0, 8'h0A);
        pulse(1);
        read_check("st_done", 8'h00, 0, 8'h0B);
        bus_write(8'h01, 0, 8'h01);
        read_check("st_rearm", 8'h00, 0, 8'h09);
        pulse(0);
        bus_write(8'h01, 0, 8'h02);
        read_check("st_abort", 8'h00, 0, 8'h08);
        bus_write(8'h01, 0, 8'h03);
        read_check("st_abort_wins", 8'h00, 0, 8'h08);
        pulse(0);
        read_check("err_enable_idle", 8'h09, 0, 8'h08);
        read_check("st_err_flag", 8'h00, 0, 8'h18);
        bus_write(8'h09, 0, 8'h08);
        read_check("err_cleared", 8'h09, 0, 8'h00);

        // ---- FIFO reads ----
        I_fifo_data = 18'h2ABCD; I_fifo_empty = 1'b0;
        @(negedge cwusb_clk);
        pop_base = pop_count;
        for (int b = 0; b < 3; b++) begin
            bus_read(8'h08, b, rd);
            check($sformatf("fifo_byte%0d", b), rd, (b == 0) ? 8'hCD : (b == 1) ? 8'hAB : 8'h02);
            @(negedge cwusb_clk);
        end
        check("fifo_one_pop", pop_count - pop_base, 1);
        I_fifo_empty = 1'b1;
        pop_base = pop_count;
        for (int b = 0; b < 3; b++) begin
            bus_read(8'h08, b, rd);
            check($sformatf("fifo_empty_byte%0d", b), rd, (b == 2) ? 8'h03 : 8'hFF);
            @(negedge cwusb_clk);
        end
        check("fifo_empty_no_pop", pop_count - pop_base, 0);
        read_check("err_fifo_empty", 8'h09, 0, 8'h01);
        bus_write(8'h09, 0, 8'h01);

        // ---- phase shift with timeout (cycle 0 is the O_psen cycle) ----
        psen_count = 0;
        bus_write(8'h07, 0, 8'h01);
        check("psen_pulse", {O_psen, O_psincdec}, 2'b11);
        bus_write(8'h07, 0, 8'h00);
        check("psen_single", O_psen, 1'b0);
        read_check("err_ps_busy", 8'h09, 0, 8'h04);
        repeat (252) @(negedge cwusb_clk);
        read_check("ps_busy_last_cycle", 8'h00, 0, 8'h1C);
        read_check("ps_busy_cleared", 8'h00, 0, 8'h18);
        read_check("err_ps_timeout", 8'h09, 0, 8'h06);
        check("psen_count", psen_count, 1);
        bus_write(8'h09, 0, 8'h07);
        read_check("err_all_cleared", 8'h09, 0, 8'h00);

        // ---- phase shift completed by psdone ----
        bus_write(8'h07, 0, 8'h00);
        check("psen_dec", {O_psen, O_psincdec}, 2'b10);
        repeat (3) @(negedge cwusb_clk);
        pulse(2);
        read_check("psdone_clears_busy", 8'h00, 0, 8'h08);
        read_check("psdone_no_error", 8'h09, 0, 8'h00);

        // ---- asynchronous reset mid-capture and mid-phase-shift ----
        bus_write(8'h01, 0, 8'h01);
        bus_write(8'h07, 0, 8'h01);
        bus_write(8'h06, 0, 8'hA5);
        reset_i = 1'b1; #1;
        check("async_reset_outputs", {O_arm, O_psen, O_psincdec, O_capture_len}, '0);
        @(negedge cwusb_clk);
        reset_i = 1'b0;
        @(negedge cwusb_clk);
        read_check("status_after_reset", 8'h00, 0, 8'h08);

        // ---- randomized register traffic against the model ----
        do_reset();
        for (int c = 0; c < 4; c++) begin m_delay[c] = 0; m_width[c] = 0; end
        m_cap = 0; m_chan = 0; m_en = 0;
        for (int i = 0; i < 200; i++) begin
            int off, bc;
            int unsigned d;
            off = int'($urandom_range(2, 6));
            bc  = int'($urandom_range(0, 4));
            d   = (off == 2) ? $urandom_range(0, 7) : $urandom_range(0, 255);
            bus_write(8'(off), bc, 8'(d));
            model_write(off, bc, d);
            off = int'($urandom_range(2, 6));
            bc  = int'($urandom_range(0, 4));
            read_check($sformatf("rand_rd_off%0d_bc%0d", off, bc), 8'(off), bc, model_read(off, bc));
            check("rand_capture_len", O_capture_len, m_cap[23:0]);
            check("rand_trig_enable", O_trigger_enable, m_en[3:0]);
        end
        for (int c = 0; c < 4; c++) begin
            exp_d[c*24 +: 24] = m_delay[c][23:0];
            exp_w[c*24 +: 24] = m_width[c][23:0];
        end
        check("rand_delay_vec", O_trigger_delay, exp_d);
        check("rand_width_vec", O_trigger_width, exp_w);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
